identify_queue: RTL and testbench
=================================

Name: identify_queue

Overview:
- Handshaked, buffered successor to the single-word identify stage. Sits between fetch and decode.
- Accepts one 32-bit instruction word per cycle together with its PC.
- Pairs prefix and suffix words into one entry, classifies branch and condition-register instructions, and flags prefix errors.
- Queues results in a parametrised FIFO so decode back-pressure does not stall identification logic.

Parameters:
DEPTH, 4, output queue entries; power of two, at least 2
PC_W, 64, PC width in bits

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_flush  input  1  discard queue and held prefix
i_valid  input  1  input word valid
o_ready  output  1  input accepted when i_valid && o_ready
i_instr  input  [0:31]  instruction word (bit 0 = MSB)
i_pc  input  [PC_W-1:0]  byte address of i_instr
o_valid  output  1  queue head valid
i_ready  input  1  consumer takes head when o_valid && i_ready
o_prefix  output  [0:31]  prefix word, 0 if not prefixed
o_suffix  output  [0:31]  instruction or suffix word
o_pc  output  [PC_W-1:0]  PC of first word of entry
o_is_prefixed  output  1  entry is prefix+suffix pair
o_branch  output  [4:0]  one-hot {TAR,CTR,LR,B,I}
o_condreg  output  [8:0]  one-hot {mcrf,crorc,crandc,creqv,crnor,crxor,cror,crnand,crand}
o_err_pfx_pfx  output  1  prefix followed by prefix
o_err_boundary  output  1  prefix at last word of 64-byte block

Behaviour:
- Reset/flush:
  - i_rst asynchronously clears queue count, pointers, holding register and state to IDLE.
  - o_valid=0 and o_ready=0 while i_rst is high; all payload outputs read 0 when o_valid=0.
  - i_flush is synchronous and takes priority over push and pop. Queue empties and state returns to IDLE on the next edge. A word presented in the flush cycle is dropped.
- Back-pressure: o_ready = (count < DEPTH). Combinational from count only, never from i_valid.
- A word is a prefix when i_instr[0:5] == 1 (opcode 1).
- FSM, two states:
  - IDLE, accepted non-prefix word: push entry {prefix=0, suffix=word, pc=i_pc, is_prefixed=0}. Stay IDLE.
  - IDLE, accepted prefix word with i_pc[5:2]==4'hF: push entry {prefix=word, suffix=0, err_boundary=1}. Stay IDLE.
  - IDLE, accepted prefix word otherwise: latch word and PC into holding register, push nothing, go to PFX.
  - PFX, accepted non-prefix word: push {prefix=held, suffix=word, pc=held pc, is_prefixed=1}. Go to IDLE.
  - PFX, accepted prefix word: push {prefix=held, suffix=word, pc=held pc, is_prefixed=1, err_pfx_pfx=1}. Go to IDLE.
- Classification uses the suffix word only. It is forced to zero for prefixed entries and error entries. Definitions:
  - op = word[0:5], xo = word[21:30].
  - I: op 18. B: op 16.
  - Op 19 with xo: LR=16, CTR=528, TAR=560, crand=257, crnand=225, cror=449, crxor=193, crnor=33, creqv=289, crandc=129, crorc=417, mcrf=0.
  - At most one bit set across o_branch|o_condreg. An unclassified instruction has both vectors zero.
- Latency: an entry pushed at edge N is visible on o_valid after edge N if the queue was empty (one-cycle registered latency). No combinational path from i_* to o_* payload.
- FIFO:
  - Push and pop in the same cycle are allowed and leave count unchanged.
  - When count==DEPTH there is no push. The pop in that cycle still occurs, and o_ready rises the following cycle.
  - Pointers wrap modulo DEPTH; count width is $clog2(DEPTH+1).
- A prefix held in PFX consumes no queue slot. PFX persists indefinitely across i_valid=0 cycles.
- Output order equals input order.

Test Plan:
- Reset, then push 0x48000010 at pc 0x1000 with i_ready=1 -> next cycle o_valid=1, o_branch=5'b00001, o_pc=0x1000, o_is_prefixed=0.
- Push 0x4E800020, 0x4E800420, 0x4C000202, 0x4C000000 back-to-back -> o_branch LR (00100), then CTR (01000); then o_condreg crand (bit0), then mcrf (bit8), in order.
- Push prefix 0x04000000 at pc 0x2000, then idle 3 cycles, then 0x38600001 -> exactly one entry: prefix=0x04000000, suffix=0x38600001, pc=0x2000, is_prefixed=1, o_branch=0, o_condreg=0.
- Push prefix at pc 0x103C -> immediate entry with o_err_boundary=1, suffix=0. Then 0x04000000 at 0x2000 followed by 0x04000000 at 0x2004 -> entry with o_err_pfx_pfx=1, pc=0x2000.
- Hold i_ready=0 while streaming 6 words, DEPTH=4 -> o_ready drops after 4th push and no word is lost. Release i_ready -> 6 entries drained in order, with count never exceeding 4.
- With 3 entries queued and state PFX, assert i_flush one cycle with i_valid=1 -> next cycle o_valid=0, o_ready=1. A following non-prefix word emerges with is_prefixed=0. Assert i_rst mid-stream -> o_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/identify_queue.sv
// Buffered identify stage: pairs prefix/suffix words, classifies branch and
// condition-register instructions, and queues results ahead of decode.
module identify_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [0:31]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [0:31]     o_prefix,
  output logic [0:31]     o_suffix,
  output logic [PC_W-1:0] o_pc,
  output logic            o_is_prefixed,
  output logic [4:0]      o_branch,
  output logic [8:0]      o_condreg,
  output logic            o_err_pfx_pfx,
  output logic            o_err_boundary
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]     prefix;
    logic [31:0]     suffix;
    logic [PC_W-1:0] pc;
    logic            is_prefixed;
    logic [4:0]      branch;
    logic [8:0]      condreg;
    logic            err_pfx_pfx;
    logic            err_boundary;
  } entry_t;

  // Returns {branch[4:0], condreg[8:0]}; all zero for unclassified words.
  function automatic logic [13:0] classify(input logic [0:31] w);
    logic [5:0] op;
    logic [9:0] xo;
    logic [4:0] br;
    logic [8:0] cr;
    op = w[0:5];
    xo = w[21:30];
    br = 5'b00000;
    cr = 9'b000000000;
    case (op)
      6'd18: br = 5'b00001;
      6'd16: br = 5'b00010;
      6'd19: begin
        case (xo)
          10'd16:  br = 5'b00100;
          10'd528: br = 5'b01000;
          10'd560: br = 5'b10000;
          10'd257: cr = 9'b000000001;
          10'd225: cr = 9'b000000010;
          10'd449: cr = 9'b000000100;
          10'd193: cr = 9'b000001000;
          10'd33:  cr = 9'b000010000;
          10'd289: cr = 9'b000100000;
          10'd129: cr = 9'b001000000;
          10'd417: cr = 9'b010000000;
          10'd0:   cr = 9'b100000000;
          default: cr = 9'b000000000;
        endcase
      end
      default: br = 5'b00000;
    endcase
    return {br, cr};
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     hold_word_q, hold_word_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t          mem_q [DEPTH];

  entry_t      entry_s;
  entry_t      head_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic        is_pfx_s;
  logic [13:0] class_s;

  assign o_ready  = !i_rst && (count_q < DEPTH_C);
  assign o_valid  = !i_rst && (count_q != {CNT_W{1'b0}});
  assign accept_s = i_valid && o_ready && !i_flush;
  assign pop_s    = o_valid && i_ready && !i_flush;
  assign is_pfx_s = (i_instr[0:5] == 6'd1);
  assign class_s  = classify(i_instr);
  assign head_s   = mem_q[rd_ptr_q];

  // Next-state and entry formation for the prefix-pairing FSM.
  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    push_s      = 1'b0;
    entry_s     = '0;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!is_pfx_s) begin
            push_s          = 1'b1;
            entry_s.suffix  = i_instr;
            entry_s.pc      = i_pc;
            entry_s.branch  = class_s[13:9];
            entry_s.condreg = class_s[8:0];
          end else if (i_pc[5:2] == 4'hF) begin
            // A prefix in the last word of a 64-byte block can never pair.
            push_s               = 1'b1;
            entry_s.prefix       = i_instr;
            entry_s.pc           = i_pc;
            entry_s.err_boundary = 1'b1;
          end else begin
            hold_word_d = i_instr;
            hold_pc_d   = i_pc;
            state_d     = ST_PFX;
          end
        end
        ST_PFX: begin
          push_s              = 1'b1;
          entry_s.prefix      = hold_word_q;
          entry_s.suffix      = i_instr;
          entry_s.pc          = hold_pc_q;
          entry_s.is_prefixed = 1'b1;
          entry_s.err_pfx_pfx = is_pfx_s;
          state_d             = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Queue pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Entry storage; contents are only observed through valid slots.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign o_prefix       = o_valid ? head_s.prefix       : 32'h0;
  assign o_suffix       = o_valid ? head_s.suffix       : 32'h0;
  assign o_pc           = o_valid ? head_s.pc           : {PC_W{1'b0}};
  assign o_is_prefixed  = o_valid ? head_s.is_prefixed  : 1'b0;
  assign o_branch       = o_valid ? head_s.branch       : 5'b00000;
  assign o_condreg      = o_valid ? head_s.condreg      : 9'b000000000;
  assign o_err_pfx_pfx  = o_valid ? head_s.err_pfx_pfx  : 1'b0;
  assign o_err_boundary = o_valid ? head_s.err_boundary : 1'b0;

endmodule

// File: tb/tb_identify_queue.sv
// Directed self-checking bench for identify_queue (DEPTH=4, PC_W=64).
module tb_identify_queue;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [0:31] i_instr = 32'h0;
  logic [63:0] i_pc = 64'h0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [0:31] o_prefix;
  logic [0:31] o_suffix;
  logic [63:0] o_pc;
  logic        o_is_prefixed;
  logic [4:0]  o_branch;
  logic [8:0]  o_condreg;
  logic        o_err_pfx_pfx;
  logic        o_err_boundary;

  int n_cmp = 0;
  int n_err = 0;

  identify_queue #(.DEPTH(4), .PC_W(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_prefix(o_prefix),
    .o_suffix(o_suffix), .o_pc(o_pc), .o_is_prefixed(o_is_prefixed),
    .o_branch(o_branch), .o_condreg(o_condreg),
    .o_err_pfx_pfx(o_err_pfx_pfx), .o_err_boundary(o_err_boundary)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [63:0] pc);
    i_valid = 1'b1;
    i_instr = w;
    i_pc    = pc;
    step();
    i_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] pfx, input logic [31:0] sfx,
                           input logic [63:0] pc, input logic pfxd, input logic [4:0] br,
                           input logic [8:0] cr, input logic epp, input logic ebd);
    check({tag, ".valid"}, 64'(o_valid), 64'd1);
    check({tag, ".prefix"}, 64'(o_prefix), 64'(pfx));
    check({tag, ".suffix"}, 64'(o_suffix), 64'(sfx));
    check({tag, ".pc"}, o_pc, pc);
    check({tag, ".pfxd"}, 64'(o_is_prefixed), 64'(pfxd));
    check({tag, ".branch"}, 64'(o_branch), 64'(br));
    check({tag, ".condreg"}, 64'(o_condreg), 64'(cr));
    check({tag, ".err_pp"}, 64'(o_err_pfx_pfx), 64'(epp));
    check({tag, ".err_bd"}, 64'(o_err_boundary), 64'(ebd));
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  logic [31:0] model_q[$];
  int sent;
  int rcv;

  initial begin
    #2;
    check("rst.valid", 64'(o_valid), 64'd0);
    check("rst.ready", 64'(o_ready), 64'd0);
    step();
    i_rst = 1'b0;
    #1;
    check("post_rst.ready", 64'(o_ready), 64'd1);
    check("post_rst.valid", 64'(o_valid), 64'd0);

    // Single branch word with consumer ready
    i_ready = 1'b1;
    push(32'h48000010, 64'h1000);
    check("b.valid", 64'(o_valid), 64'd1);
    check("b.branch", 64'(o_branch), 64'h01);
    check("b.pc", o_pc, 64'h1000);
    check("b.pfxd", 64'(o_is_prefixed), 64'd0);
    step();
    check("b.drained", 64'(o_valid), 64'd0);
    i_ready = 1'b0;

    // Back-to-back classification in order
    push(32'h4E800020, 64'h1004);
    push(32'h4E800420, 64'h1008);
    push(32'h4C000202, 64'h100C);
    push(32'h4C000000, 64'h1010);
    check("full.ready", 64'(o_ready), 64'd0);
    pop_check("lr",    32'h0, 32'h4E800020, 64'h1004, 1'b0, 5'b00100, 9'h000, 1'b0, 1'b0);
    pop_check("ctr",   32'h0, 32'h4E800420, 64'h1008, 1'b0, 5'b01000, 9'h000, 1'b0, 1'b0);
    pop_check("crand", 32'h0, 32'h4C000202, 64'h100C, 1'b0, 5'b00000, 9'h001, 1'b0, 1'b0);
    pop_check("mcrf",  32'h0, 32'h4C000000, 64'h1010, 1'b0, 5'b00000, 9'h100, 1'b0, 1'b0);
    check("cls.empty", 64'(o_valid), 64'd0);

    // Prefix held across idle cycles
    push(32'h04000000, 64'h2000);
    step(); step(); step();
    check("hold.novalid", 64'(o_valid), 64'd0);
    push(32'h38600001, 64'h2004);
    pop_check("pair", 32'h04000000, 32'h38600001, 64'h2000, 1'b1, 5'b0, 9'h0, 1'b0, 1'b0);
    check("pair.single", 64'(o_valid), 64'd0);

    // Boundary prefix and prefix-prefix error
    push(32'h04000000, 64'h103C);
    pop_check("bound", 32'h04000000, 32'h0, 64'h103C, 1'b0, 5'b0, 9'h0, 1'b0, 1'b1);
    push(32'h04000000, 64'h2000);
    push(32'h04000000, 64'h2004);
    pop_check("pfxpfx", 32'h04000000, 32'h04000000, 64'h2000, 1'b1, 5'b0, 9'h0, 1'b1, 1'b0);

    // Back-pressure stream: 6 words, consumer released after a stall
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      if (cyc == 12) i_ready = 1'b1;
      i_valid = (sent < 6);
      i_instr = 32'h38600000 | 32'(sent);
      i_pc    = 64'h3000 + 64'(4 * sent);
      #0;
      check("bp.ready", 64'(o_ready), 64'(model_q.size() < 4));
      if (o_valid && i_ready) begin
        check("bp.order", 64'(o_suffix), 64'(model_q.pop_front()));
        rcv++;
      end
      if (i_valid && o_ready) begin
        model_q.push_back(i_instr);
        sent++;
      end
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("bp.received", 64'(rcv), 64'd6);
    check("bp.empty", 64'(o_valid), 64'd0);

    // Flush with three queued entries and a held prefix
    push(32'h38600010, 64'h4000);
    push(32'h38600011, 64'h4004);
    push(32'h38600012, 64'h4008);
    push(32'h04000000, 64'h400C);
    i_flush = 1'b1;
    push(32'h48000010, 64'h4010);
    i_flush = 1'b0;
    check("flush.valid", 64'(o_valid), 64'd0);
    check("flush.ready", 64'(o_ready), 64'd1);
    push(32'h38600005, 64'h4100);
    pop_check("postflush", 32'h0, 32'h38600005, 64'h4100, 1'b0, 5'b0, 9'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    push(32'h38600020, 64'h5000);
    push(32'h38600021, 64'h5004);
    check("prerst.valid", 64'(o_valid), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst.valid", 64'(o_valid), 64'd0);
    check("arst.ready", 64'(o_ready), 64'd0);
    step();
    i_rst = 1'b0;
    step();
    check("arst.after", 64'(o_valid), 64'd0);
    check("arst.ready_after", 64'(o_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
